// File: rtl/insn_fetch_if.sv
// Instruction-memory bus between the fetch stage and a combinational imem.
// Fetch drives the byte address; memory returns the 32-bit word.
interface insn_fetch_if;
  logic [63:0] mem_addr;
  logic [31:0] mem_insn;

  modport master (
    output mem_addr,
    input  mem_insn
  );

  modport slave (
    input  mem_addr,
    output mem_insn
  );
endinterface

// File: rtl/insn_fetch.sv
// RV64 instruction-fetch stage: PC, imem address and IF/ID register.
// Define FETCH_MISALIGN_TRAP_EN to build the misaligned-fetch FAULT state.
module insn_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [63:0]         redirect_pc,
  insn_fetch_if.master        imem,
  output logic                if_valid,
  output logic [63:0]         if_pc,
  output logic [31:0]         if_insn,
  output logic [63:0]         if_pc_plus4,
  output logic                if_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1
  } state_t;
`endif

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] insn;
    logic [63:0] pc4;
  } if_id_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  if_id_t      ifid_q, ifid_d;
  logic [63:0] tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fault_q, fault_d;
  logic        misal;

  assign tgt   = redirect_pc;
  assign misal = |redirect_pc[1:0];
`else
  assign tgt   = redirect_pc & ~64'h3;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ifid_q  <= '{valid: 1'b0, pc: 64'h0,
                   insn: NOP, pc4: 64'h0};
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d = fault_q;
`endif
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        if (redirect_valid) begin
          pc_d = tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (misal) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        // Redirect beats stall: the held instruction is squashed.
        if (redirect_valid) begin
          pc_d         = tgt;
          ifid_d.valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (misal) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
`endif
        end else if (!stall) begin
          ifid_d.valid = 1'b1;
          ifid_d.pc    = pc_q;
          ifid_d.insn  = imem.mem_insn;
          ifid_d.pc4   = pc_q + 64'd4;
          pc_d         = pc_q + 64'd4;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      FAULT: begin
        if (redirect_valid) begin
          pc_d = tgt;
          if (!misal) begin
            state_d = RUN;
            fault_d = 1'b0;
          end
        end
      end
`endif
      default: state_d = BOOT;
    endcase
  end

  assign imem.mem_addr = pc_q;
  assign if_valid      = ifid_q.valid;
  assign if_pc         = ifid_q.pc;
  assign if_insn       = ifid_q.insn;
  assign if_pc_plus4   = ifid_q.pc4;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign if_fault      = fault_q;
`else
  assign if_fault      = 1'b0;
`endif

endmodule

// File: doc/insn_fetch.md
# insn_fetch

Instruction-fetch stage of the RV64F datapath. Holds the program counter and drives the address into the combinational instruction memory. Captures the returned 32-bit instruction into the IF/ID pipeline register together with its PC. Handles decode-stage stalls and branch/jump redirects from downstream.

## Interface
- `RESET_PC`, default `64'h0`: PC value loaded on reset.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stall`  in  1: downstream cannot accept. Hold PC and the IF/ID register.
- `redirect_valid`  in  1: taken branch or jump. Load `redirect_pc` and squash the in-flight fetch.
- `redirect_pc`  in  64: redirect target byte address.
- `mem_addr`  out  64: byte address to the instruction memory. Combinational from PC.
- `mem_insn`  in  32: little-endian instruction word returned combinationally for `mem_addr`.
- `if_valid`  out  1: IF/ID register holds a real instruction.
- `if_pc`  out  64: PC of `if_insn`.
- `if_insn`  out  32: latched instruction.
- `if_pc_plus4`  out  64: `if_pc + 4`, registered.
- `if_fault`  out  1: misaligned-fetch fault pending. Only driven when the configuration macro is enabled; otherwise tied to 0.

## Operation
- Clock is `clk`. Reset is asynchronous and active-low on `rst_n`.
- State machine states:
  - BOOT: entered on reset; no fetch is captured.
  - RUN: normal fetch.
  - FAULT: fetch halted; exists only when the macro is enabled.
- Reset values:
  - state = BOOT, PC = `RESET_PC`.
  - `if_valid` = 0, `if_pc` = 0, `if_insn` = `32'h00000013` (NOP), `if_pc_plus4` = 0, `if_fault` = 0.
- `mem_addr` = PC at all times, including BOOT and FAULT.
- BOOT → RUN on the first clock edge after reset is released, unconditionally. PC is unchanged and `if_valid` stays 0.
- Priority in RUN is: redirect, then stall, then advance.
  - redirect: PC ← target, `if_valid` ← 0, IF/ID data fields hold.
  - stall: PC holds and the whole IF/ID register holds, including `if_valid`.
  - advance: `if_pc` ← PC, `if_insn` ← `mem_insn`, `if_pc_plus4` ← PC+4, `if_valid` ← 1, PC ← PC+4.
- When `redirect_valid` and `stall` are both high, the redirect wins. The instruction held in IF/ID is discarded; the downstream stage is responsible for the branch outcome.
- `redirect_valid` during BOOT loads PC and moves to RUN. `stall` during BOOT is ignored.
- PC arithmetic is 64-bit modulo 2^64: `64'hFFFF_FFFF_FFFF_FFFC` + 4 wraps to 0 with no flag.
- `rst_n` asserted mid-operation returns every register to its reset value immediately, without waiting for a clock edge.

## Timing
- Redirect latency:
  - `redirect_valid` sampled at edge n.
  - `mem_addr` equals the target after edge n.
  - The target instruction appears with `if_valid`=1 after edge n+1.
  - Exactly one bubble per redirect.
- Sequential fetch: one instruction per cycle when not stalled. Latency from PC to `if_insn` is 1 edge.
- First valid instruction appears two edges after reset release: the BOOT edge, then the capture edge.
- Stall has zero-cycle effect: outputs sampled at edge n with `stall`=1 are identical after edge n.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` loads PC with the raw target and enters FAULT. After that edge, `if_valid`=0 and `if_fault`=1.
  - FAULT holds PC and ignores `stall`.
  - Only a redirect with an aligned target leaves FAULT: `if_fault` ← 0, state ← RUN, normal redirect timing applies.
  - A misaligned redirect while in FAULT stays in FAULT and updates PC.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - No FAULT state is built.
  - The redirect loads `{redirect_pc[63:2], 2'b00}`.
  - `if_fault` is constant 0.

## Test plan
- Reset with `RESET_PC`=0, memory words 0x00100093, 0x00200113 at 0 and 4, release reset → one edge with `if_valid`=0, then `if_insn`=0x00100093 with `if_pc`=0, then 0x00200113 with `if_pc`=4 and `if_pc_plus4`=8.
- `stall` high for 3 cycles while `if_pc`=8 → `if_pc`, `if_insn`, `if_valid` and `mem_addr`=12 unchanged for 3 cycles; the fetch from 12 resumes the cycle after `stall` drops.
- `redirect_valid` with `redirect_pc`=0x40 while `stall`=1 → `if_valid`=0 next cycle, `mem_addr`=0x40, then `if_pc`=0x40 valid; exactly one bubble.
- PC forced via redirect to `64'hFFFF_FFFF_FFFF_FFFC` → after capture, `mem_addr`=0 and `if_pc_plus4`=0.
- With `FETCH_MISALIGN_TRAP_EN`: redirect to 0x42 → `if_fault`=1 and `if_valid`=0 held for 5 cycles; then redirect to 0x44 → `if_fault`=0 and `if_pc`=0x44 valid two edges later. Without the macro: the same redirect to 0x42 gives `mem_addr`=0x40 and `if_fault`=0.
- `rst_n` pulsed low mid-fetch at PC=0x20, asynchronous to `clk` → outputs reach their reset values before the next edge; the BOOT bubble repeats.
